// File: rtl/fp_mac_div_pkg.sv
// Shared types, constants and the reciprocal seed function for the Newton-Raphson mantissa divider.
package fp_mac_div_pkg;

  localparam int unsigned MANT_W = 53;
  localparam int unsigned FIX_W  = 56;
  localparam int unsigned FRAC_W = 54;
  localparam int unsigned RES_W  = 110;

  localparam logic [FIX_W-1:0] FP_ONE_Q254 = 56'h40_0000_0000_0000;

  typedef struct packed {
    logic [FIX_W-1:0] a;
    logic [FIX_W-1:0] b;
    logic [FIX_W-1:0] c;
    logic             op;
  } fp_mac_in_type;

  typedef struct packed {
    logic [RES_W-1:0] d;
  } fp_mac_out_type;

  typedef struct packed {
    logic [MANT_W-1:0] x;
    logic [MANT_W-1:0] d;
  } fp_mac_div_in_type;

  typedef struct packed {
    logic [FIX_W-1:0] q;
    logic             rem_neg;
    logic             rem_zero;
    logic             err;
  } fp_mac_div_out_type;

  typedef enum logic [2:0] {IDLE, SEED, ERR, UPD, QUO, REM, DONE} fp_mac_div_state_type;

  // y0 = 1/(1+(i+0.5)/2^L) rounded to L+2 fraction bits, returned in Q2.54.
  function automatic logic [FIX_W-1:0] fp_mac_div_seed(input int unsigned index,
                                                        input int unsigned lut_bits);
    longint unsigned den;
    longint unsigned num;
    longint unsigned y;
    den = (64'd1 << (lut_bits + 1)) + 64'(2 * index) + 64'd1;
    num = 64'd1 << (2 * lut_bits + 4);
    y   = (num + den) / (64'd2 * den);
    return FIX_W'(y) << (FRAC_W - lut_bits - 2);
  endfunction

endpackage

// File: rtl/fp_mac_div_lut.sv
// Registered reciprocal seed ROM indexed by the leading divisor fraction bits.
module fp_mac_div_lut
  import fp_mac_div_pkg::*;
#(
  parameter int unsigned LUT_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [LUT_BITS-1:0] index,
  output logic [FIX_W-1:0]    seed
);

  localparam int unsigned DEPTH = 2 ** LUT_BITS;

  logic [FIX_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
    assign rom[i] = fp_mac_div_seed(unsigned'(i), LUT_BITS);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) seed <= '0;
    else if (en) seed <= rom[index];
  end

endmodule

// File: rtl/fp_mac_div.sv
// Iterative Newton-Raphson mantissa divider driving an external shared fp_mac, one request per cycle.
module fp_mac_div
  import fp_mac_div_pkg::*;
#(
  parameter int unsigned LUT_BITS = 8,
  parameter int unsigned ITER     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] x_i,
  input  logic [MANT_W-1:0] d_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FIX_W-1:0]  q_o,
  output logic              rem_neg_o,
  output logic              rem_zero_o,
  output logic              err_o,
  output fp_mac_in_type     mac_i,
  input  fp_mac_out_type    mac_o
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);

  fp_mac_div_state_type state, state_nx;
  logic [FIX_W-1:0] x_q, d_q, y_q, e_q;
  logic [FIX_W-1:0] x_nx, d_nx, y_nx, e_nx, q_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             in_ready_nx, out_valid_nx, rem_neg_nx, rem_zero_nx, err_nx;
  fp_mac_in_type    mac_nx;
  logic [FIX_W-1:0] seed;
  logic [FIX_W-1:0] res_fix;
  logic             bad_op;

  assign bad_op  = !x_i[MANT_W-1] || !d_i[MANT_W-1];
  assign res_fix = mac_o.d[RES_W-1 -: FIX_W];

  fp_mac_div_lut #(.LUT_BITS(LUT_BITS)) u_lut (
    .clock (clock),
    .reset (reset),
    .en    (state == IDLE && in_valid),
    .index (d_i[MANT_W-2 -: LUT_BITS]),
    .seed  (seed)
  );

  // Next state, datapath next values, and the mac request for the state being entered.
  always_comb begin
    state_nx     = state;
    x_nx         = x_q;
    d_nx         = d_q;
    y_nx         = y_q;
    e_nx         = e_q;
    q_nx         = q_o;
    cnt_nx       = cnt_q;
    rem_neg_nx   = rem_neg_o;
    rem_zero_nx  = rem_zero_o;
    err_nx       = err_o;
    out_valid_nx = 1'b0;
    mac_nx       = '0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          x_nx        = {1'b0, x_i, 2'b00};
          d_nx        = {1'b0, d_i, 2'b00};
          cnt_nx      = '0;
          err_nx      = bad_op;
          rem_neg_nx  = 1'b0;
          rem_zero_nx = 1'b0;
          if (bad_op) begin
            q_nx     = '0;
            state_nx = DONE;
          end else begin
            state_nx = SEED;
          end
        end
      end
      SEED: begin
        y_nx     = seed;
        state_nx = ERR;
      end
      ERR: begin
        e_nx     = res_fix;
        state_nx = UPD;
      end
      UPD: begin
        y_nx     = res_fix;
        cnt_nx   = cnt_q + 1'b1;
        state_nx = (cnt_nx == CNT_W'(ITER)) ? QUO : ERR;
      end
      QUO: begin
        q_nx     = res_fix;
        state_nx = REM;
      end
      REM: begin
        rem_neg_nx  = mac_o.d[RES_W-1];
        rem_zero_nx = (mac_o.d == '0);
        state_nx    = DONE;
      end
      DONE: begin
        out_valid_nx = 1'b1;
        if (out_valid && out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    in_ready_nx = (state_nx == IDLE);

    // mac_i is registered, so it is set up from the values that will be live in the next state.
    unique case (state_nx)
      ERR:     mac_nx = '{a: FP_ONE_Q254, b: d_nx, c: y_nx, op: 1'b1};
      UPD:     mac_nx = '{a: y_nx, b: y_nx, c: e_nx, op: 1'b0};
      QUO:     mac_nx = '{a: '0, b: x_nx, c: y_nx, op: 1'b0};
      REM:     mac_nx = '{a: x_nx, b: d_nx, c: q_nx, op: 1'b1};
      default: mac_nx = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      q_o        <= '0;
      rem_neg_o  <= 1'b0;
      rem_zero_o <= 1'b0;
      err_o      <= 1'b0;
      mac_i      <= '0;
      x_q        <= '0;
      d_q        <= '0;
      y_q        <= '0;
      e_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nx;
      in_ready   <= in_ready_nx;
      out_valid  <= out_valid_nx;
      q_o        <= q_nx;
      rem_neg_o  <= rem_neg_nx;
      rem_zero_o <= rem_zero_nx;
      err_o      <= err_nx;
      mac_i      <= mac_nx;
      x_q        <= x_nx;
      d_q        <= d_nx;
      y_q        <= y_nx;
      e_q        <= e_nx;
      cnt_q      <= cnt_nx;
    end
  end

endmodule
